watch_mode_ctrl: RTL and testbench

User-interface controller for the watch time datapath. It turns four raw push-button levels into the time-keeper's `clock_enable` mode select and single-cycle `min_inc`/`min_dec`/`hour_inc`/`hour_dec` set pulses. It also produces stopwatch run/clear controls and a display blink enable. It sits between the button pads and the digital clock / stopwatch counters, and all of its outputs are registered.

---
 rtl/watch_mode_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_watch_mode_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_mode_ctrl.sv
// Watch user-interface controller: button sync/edge detect, mode FSM, set pulses,
// stopwatch controls, SET timeout and blink. Auto-repeat is built only with WATCH_AUTOREPEAT_EN.
module watch_mode_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 2,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned BLINK_HALF    = 4
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       mode_btn,
  input  logic       set_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic [1:0] mode,
  output logic       clock_enable,
  output logic       min_inc,
  output logic       min_dec,
  output logic       hour_inc,
  output logic       hour_dec,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       blink
);

  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_SET  = 1;
  localparam int unsigned B_UP   = 2;
  localparam int unsigned B_DOWN = 3;
  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    ST_TIME      = 2'b00,
    ST_SET_HOUR  = 2'b01,
    ST_SET_MIN   = 2'b10,
    ST_STOPWATCH = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      btn_raw;
  logic [3:0]      sync1_q, sync2_q, edge_q, press_q;
  logic            clk_en_q, clk_en_d;
  logic            min_inc_q, min_inc_d, min_dec_q, min_dec_d;
  logic            hour_inc_q, hour_inc_d, hour_dec_q, hour_dec_d;
  logic            sw_run_q, sw_run_d, sw_clear_q, sw_clear_d;
  logic            blink_q, blink_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            p_mode, p_set, p_up, p_down;
  logic            in_set, rpt_up, rpt_down;
  logic            ev_up, ev_down;
  logic            set_next, entering, set_pulse;

  assign btn_raw = {down_btn, up_btn, set_btn, mode_btn};

  // Press strobe is registered so every button reaches its output three edges after first sampling.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      press_q <= sync2_q & ~edge_q;
    end
  end

  assign p_mode = press_q[B_MODE];
  assign p_set  = press_q[B_SET] & ~press_q[B_MODE];
  assign p_up   = press_q[B_UP] & ~press_q[B_MODE] & ~press_q[B_SET] & ~press_q[B_DOWN];
  assign p_down = press_q[B_DOWN] & ~press_q[B_MODE] & ~press_q[B_SET] & ~press_q[B_UP];
  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

`ifdef WATCH_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic          rpt_act_q, rpt_act_d, rpt_btn_q, rpt_btn_d, rpt_first_q, rpt_first_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_thr;
  logic          rpt_held, rpt_fire;

  assign rpt_held = rpt_btn_q ? sync2_q[B_DOWN] : sync2_q[B_UP];
  assign rpt_thr  = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign rpt_fire = rpt_act_q & rpt_held & ~(|press_q) & in_set & (rpt_cnt_q == rpt_thr);
  assign rpt_up   = rpt_fire & ~rpt_btn_q;
  assign rpt_down = rpt_fire & rpt_btn_q;

  always_comb begin
    rpt_act_d   = rpt_act_q;
    rpt_btn_d   = rpt_btn_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    if (in_set && (p_up || p_down)) begin
      rpt_act_d   = 1'b1;
      rpt_btn_d   = p_down;
      rpt_first_d = 1'b1;
      rpt_cnt_d   = '0;
    end else if (!rpt_act_q || (|press_q) || !rpt_held || (state_d != state_q)) begin
      rpt_act_d   = 1'b0;
      rpt_first_d = 1'b0;
      rpt_cnt_d   = '0;
    end else if (rpt_fire) begin
      rpt_first_d = 1'b0;
      rpt_cnt_d   = '0;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + RW'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_act_q   <= 1'b0;
      rpt_btn_q   <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_act_q   <= rpt_act_d;
      rpt_btn_q   <= rpt_btn_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  // Repeat timing has no effect when auto-repeat is compiled out.
  assign rpt_up   = 1'b0 & (REPEAT_DELAY != 0);
  assign rpt_down = 1'b0 & (REPEAT_PERIOD != 0);
`endif

  assign ev_up   = in_set & (p_up | rpt_up);
  assign ev_down = in_set & (p_down | rpt_down);

  always_comb begin
    state_d    = state_q;
    sw_run_d   = sw_run_q;
    min_inc_d  = 1'b0;
    min_dec_d  = 1'b0;
    hour_inc_d = 1'b0;
    hour_dec_d = 1'b0;
    sw_clear_d = 1'b0;
    case (state_q)
      ST_TIME: begin
        if (p_mode)     state_d = ST_STOPWATCH;
        else if (p_set) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (p_mode)                            state_d    = ST_TIME;
        else if (p_set)                        state_d    = ST_SET_MIN;
        else if (ev_up)                        hour_inc_d = 1'b1;
        else if (ev_down)                      hour_dec_d = 1'b1;
        else if (idle_q == IW'(TIMEOUT - 1))   state_d    = ST_TIME;
      end
      ST_SET_MIN: begin
        if (p_mode)                            state_d   = ST_TIME;
        else if (p_set)                        state_d   = ST_TIME;
        else if (ev_up)                        min_inc_d = 1'b1;
        else if (ev_down)                      min_dec_d = 1'b1;
        else if (idle_q == IW'(TIMEOUT - 1))   state_d   = ST_TIME;
      end
      ST_STOPWATCH: begin
        if (p_mode)                    state_d    = ST_TIME;
        else if (p_set)                sw_run_d   = ~sw_run_q;
        else if (p_down && !sw_run_q)  sw_clear_d = 1'b1;
      end
      default: state_d = ST_TIME;
    endcase

    clk_en_d  = (state_d != ST_STOPWATCH);
    set_next  = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
    entering  = set_next && (state_d != state_q);
    set_pulse = min_inc_d | min_dec_d | hour_inc_d | hour_dec_d;

    idle_d      = '0;
    blink_d     = 1'b0;
    blink_cnt_d = '0;
    if (set_next) begin
      if (entering || set_pulse) begin
        blink_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
          blink_d = ~blink_q;
        end else begin
          blink_d     = blink_q;
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_TIME;
      clk_en_q    <= 1'b1;
      min_inc_q   <= 1'b0;
      min_dec_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      hour_dec_q  <= 1'b0;
      sw_run_q    <= 1'b0;
      sw_clear_q  <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      clk_en_q    <= clk_en_d;
      min_inc_q   <= min_inc_d;
      min_dec_q   <= min_dec_d;
      hour_inc_q  <= hour_inc_d;
      hour_dec_q  <= hour_dec_d;
      sw_run_q    <= sw_run_d;
      sw_clear_q  <= sw_clear_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign mode         = state_q;
  assign clock_enable = clk_en_q;
  assign min_inc      = min_inc_q;
  assign min_dec      = min_dec_q;
  assign hour_inc     = hour_inc_q;
  assign hour_dec     = hour_dec_q;
  assign sw_run       = sw_run_q;
  assign sw_clear     = sw_clear_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: pulse scoreboard keyed by cycle plus level checks.
module tb_watch_mode_ctrl;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_btn = 1'b0, set_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
  logic [1:0] mode;
  logic       clock_enable, min_inc, min_dec, hour_inc, hour_dec, sw_run, sw_clear, blink;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int act_q[$];

  // Pulse kinds: 0 min_inc, 1 min_dec, 2 hour_inc, 3 hour_dec, 4 sw_clear; event = cycle*8+kind.
  localparam int K_MIN_INC = 0, K_MIN_DEC = 1, K_HOUR_INC = 2, K_SW_CLEAR = 4;

  watch_mode_ctrl dut (
    .Clk(Clk), .reset_n(reset_n),
    .mode_btn(mode_btn), .set_btn(set_btn), .up_btn(up_btn), .down_btn(down_btn),
    .mode(mode), .clock_enable(clock_enable),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .sw_run(sw_run), .sw_clear(sw_clear), .blink(blink)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (reset_n) begin
      if (min_inc)  act_q.push_back(cyc * 8 + 0);
      if (min_dec)  act_q.push_back(cyc * 8 + 1);
      if (hour_inc) act_q.push_back(cyc * 8 + 2);
      if (hour_dec) act_q.push_back(cyc * 8 + 3);
      if (sw_clear) act_q.push_back(cyc * 8 + 4);
    end
  end

  task automatic drive(input int b, input logic v);
    case (b)
      0: mode_btn = v;
      1: set_btn  = v;
      2: up_btn   = v;
      default: down_btn = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, output int t);
    t = cyc;
    drive(b, 1'b1);
    repeat (hold) @(negedge Clk);
    drive(b, 1'b0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge Clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk);
    checks++;
    if ({mode, clock_enable, blink, sw_run} !== 5'b00100) begin
      errors++; $display("FAIL reset_levels got %b want 00100", {mode, clock_enable, blink, sw_run});
    end
    checks++;
    if ({min_inc, min_dec, hour_inc, hour_dec, sw_clear} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 00000", {min_inc, min_dec, hour_inc, hour_dec, sw_clear});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (mode !== 2'b00 || clock_enable !== 1'b1) begin
      errors++; $display("FAIL post_reset got mode %b ce %b want 00 1", mode, clock_enable);
    end
  endtask

  task automatic test_set_entry;
    int t;
    press(1, 1, t);
    wait_until(t + 3);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL set_latency_early got %b want 00", mode); end
    wait_until(t + 4);
    checks++;
    if ({mode, blink, clock_enable} !== 4'b0111) begin
      errors++; $display("FAIL set_entry got %b want 0111", {mode, blink, clock_enable});
    end
    wait_until(t + 8);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL set_entry_pulses got %0d want %0d", act_q.size(), exp_q.size());
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_conflict;
    int t, e, a;
    press(2, 1, t);
    exp_q.push_back((t + 4) * 8 + K_HOUR_INC);
    wait_until(t + 8);
    t = cyc; up_btn = 1'b1; down_btn = 1'b1;
    @(negedge Clk); up_btn = 1'b0; down_btn = 1'b0;
    wait_until(t + 8);
    checks++;
    if (mode !== 2'b01) begin errors++; $display("FAIL updown_mode got %b want 01", mode); end
    t = cyc; mode_btn = 1'b1; up_btn = 1'b1;
    @(negedge Clk); mode_btn = 1'b0; up_btn = 1'b0;
    wait_until(t + 4);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL mode_over_up got %b want 00", mode); end
    wait_until(t + 8);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL conflict_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL conflict_event got %0d/%0d want %0d/%0d", a / 8, a % 8, e / 8, e % 8); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_min_pulses;
    int t, u, d, e, a;
    press(1, 1, t); wait_until(t + 6);
    press(1, 1, t); wait_until(t + 4);
    checks++;
    if (mode !== 2'b10) begin errors++; $display("FAIL set_min_mode got %b want 10", mode); end
    wait_until(t + 9);
    press(2, 1, u);
    exp_q.push_back((u + 4) * 8 + K_MIN_INC);
    wait_until(u + 4);
    checks++;
    if (blink !== 1'b1) begin errors++; $display("FAIL inc_blink0 got %b want 1", blink); end
    wait_until(u + 7);
    checks++;
    if (blink !== 1'b1) begin errors++; $display("FAIL inc_blink3 got %b want 1", blink); end
    wait_until(u + 8);
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL inc_blink4 got %b want 0", blink); end
    wait_until(u + 10);
    press(3, 1, d);
    exp_q.push_back((d + 4) * 8 + K_MIN_DEC);
    wait_until(d + 7);
    checks++;
    if (blink !== 1'b1) begin errors++; $display("FAIL dec_blink3 got %b want 1", blink); end
    wait_until(d + 8);
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL dec_blink4 got %b want 0", blink); end
    wait_until(d + 10);
    press(1, 1, t); wait_until(t + 4);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL set_exit got %b want 00", mode); end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL minpulse_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL minpulse_event got %0d/%0d want %0d/%0d", a / 8, a % 8, e / 8, e % 8); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_timeout;
    int t, en;
    press(1, 1, t);
    en = t + 4;
    wait_until(en + 3);
    checks++;
    if (blink !== 1'b1) begin errors++; $display("FAIL to_blink3 got %b want 1", blink); end
    wait_until(en + 4);
    checks++;
    if (blink !== 1'b0) begin errors++; $display("FAIL to_blink4 got %b want 0", blink); end
    wait_until(en + 63);
    checks++;
    if (mode !== 2'b01) begin errors++; $display("FAIL to_early got %b want 01", mode); end
    wait_until(en + 64);
    checks++;
    if ({mode, blink} !== 3'b000) begin errors++; $display("FAIL to_expire got %b want 000", {mode, blink}); end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL to_pulses got %0d want 0", act_q.size()); end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_stopwatch;
    int t, e, a;
    press(0, 1, t); wait_until(t + 4);
    checks++;
    if ({mode, clock_enable} !== 3'b110) begin errors++; $display("FAIL sw_enter got %b want 110", {mode, clock_enable}); end
    press(1, 1, t); wait_until(t + 4);
    checks++;
    if ({sw_run, clock_enable} !== 2'b10) begin errors++; $display("FAIL sw_start got %b want 10", {sw_run, clock_enable}); end
    press(3, 1, t); wait_until(t + 8);
    press(1, 1, t); wait_until(t + 4);
    checks++;
    if (sw_run !== 1'b0) begin errors++; $display("FAIL sw_stop got %b want 0", sw_run); end
    press(3, 1, t);
    exp_q.push_back((t + 4) * 8 + K_SW_CLEAR);
    wait_until(t + 8);
    press(1, 1, t); wait_until(t + 4);
    press(0, 1, t); wait_until(t + 4);
    checks++;
    if ({mode, sw_run, clock_enable} !== 4'b0011) begin
      errors++; $display("FAIL sw_run_held got %b want 0011", {mode, sw_run, clock_enable});
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sw_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL sw_event got %0d/%0d want %0d/%0d", a / 8, a % 8, e / 8, e % 8); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_autorepeat;
    int t, p, e, a;
    press(1, 1, t); wait_until(t + 6);
    press(1, 1, t); wait_until(t + 6);
    press(2, 22, t);
    p = t + 4;
    exp_q.push_back(p * 8 + K_MIN_INC);
`ifdef WATCH_AUTOREPEAT_EN
    for (int k = 8; k <= 20; k += 2) exp_q.push_back((p + k) * 8 + K_MIN_INC);
`endif
    wait_until(p + 26);
    press(1, 1, t); wait_until(t + 4);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL rpt_exit got %b want 00", mode); end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rpt_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL rpt_event got %0d/%0d want %0d/%0d", a / 8, a % 8, e / 8, e % 8); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_reset_midset;
    int t, r;
    press(1, 1, t); wait_until(t + 6);
    set_btn = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mode, blink, clock_enable} !== 4'b0001) begin
      errors++; $display("FAIL rst_abort got %b want 0001", {mode, blink, clock_enable});
    end
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    r = cyc;
    wait_until(r + 3);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL held_early got %b want 00", mode); end
    wait_until(r + 4);
    checks++;
    if (mode !== 2'b01) begin errors++; $display("FAIL held_press got %b want 01", mode); end
    set_btn = 1'b0;
    wait_until(r + 8);
    press(0, 1, t); wait_until(t + 4);
    checks++;
    if (mode !== 2'b00 || act_q.size() != 0) begin
      errors++; $display("FAIL held_exit got mode %b pulses %0d want 00 0", mode, act_q.size());
    end
    exp_q.delete(); act_q.delete();
  endtask

  initial begin
    test_reset();
    test_set_entry();
    test_conflict();
    test_min_pulses();
    test_timeout();
    test_stopwatch();
    test_autorepeat();
    test_reset_midset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
